// File: rtl/alu_result_tx_pkg.sv
// Shared types and frame helpers for the ALU result serializer.
// A result word is split into a three-byte frame carrying a rolling sequence number.
package alu_result_tx_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_BYTE_A,
      TX_BYTE_B,
      TX_BYTE_C
   } tx_state_e;

   typedef struct packed {
      logic        carry;
      logic [17:0] res;
   } res_word_t;

   localparam int TX_FRAME_BYTES = 3;
   localparam int TX_SEQ_W       = 3;

   // idx 0/1 are the low/high result bytes; the last byte packs carry, seq and res[17:16].
   function automatic logic [7:0] frame_byte(input res_word_t w,
                                             input logic [TX_SEQ_W-1:0] seq,
                                             input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w.res[7:0];
         2'd1:    b = w.res[15:8];
         default: b = {w.carry, seq, 2'b00, w.res[17:16]};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// Handshake bundle between the ALU stage, the serializer and the byte consumer.
// The slave side is the serializer; the master side drives results and out_ready.
interface alu_result_tx_if;
   logic        res_valid;
   logic        res_ready;
   logic [17:0] res_q;
   logic        carry_q;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;

   modport slave (
      input  res_valid, res_q, carry_q, out_ready,
      output res_ready, out_valid, out_data, out_last
   );

   modport master (
      output res_valid, res_q, carry_q, out_ready,
      input  res_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/alu_result_tx_res_fifo.sv
// Small synchronous FIFO of result words; the head entry is readable without a pop.
// Pointers wrap naturally because DEPTH is a power of two.
module res_fifo
   import alu_result_tx_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  res_word_t        i_data,
   output res_word_t        o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   res_word_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/alu_result_tx.sv
// Buffers ALU results and serializes each into a three-byte frame on an 8-bit stream.
// Back-to-back frames chain from the last byte straight into the next first byte.
module alu_result_tx
   import alu_result_tx_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_result_tx_if.slave  bus,
   output logic            busy
);
   localparam int         CNT_W     = $clog2(DEPTH + 1);
   localparam logic [1:0] LAST_IDX  = 2'(TX_FRAME_BYTES - 1);
   localparam logic [1:0] FIRST_IDX = MSB_FIRST ? LAST_IDX : 2'd0;
   localparam logic [1:0] FINAL_IDX = MSB_FIRST ? 2'd0 : LAST_IDX;

   tx_state_e             r_state;
   tx_state_e             w_state_next;
   res_word_t             r_frame;
   logic [TX_SEQ_W-1:0]   r_seq;
   res_word_t             w_fifo_data;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic                  w_pop;

   // res_ready comes only from FIFO state, so a same-cycle pop never opens the input.
   assign bus.res_ready = !w_full;
   assign busy          = (w_count != '0) || (r_state != TX_IDLE);

   res_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (bus.res_valid),
      .i_pop   (w_pop),
      .i_data  ({bus.carry_q, bus.res_q}),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= TX_IDLE;
         r_frame <= '0;
         r_seq   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_pop) r_frame <= w_fifo_data;
         if (r_state == TX_BYTE_C && bus.out_ready) r_seq <= r_seq + 1'b1;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_pop         = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_data  = 8'h00;
      case (r_state)
         TX_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = TX_BYTE_A;
            end
         end
         TX_BYTE_A: begin
            bus.out_valid = 1'b1;
            bus.out_data  = frame_byte(r_frame, r_seq, FIRST_IDX);
            if (bus.out_ready) w_state_next = TX_BYTE_B;
         end
         TX_BYTE_B: begin
            bus.out_valid = 1'b1;
            bus.out_data  = frame_byte(r_frame, r_seq, 2'd1);
            if (bus.out_ready) w_state_next = TX_BYTE_C;
         end
         TX_BYTE_C: begin
            bus.out_valid = 1'b1;
            bus.out_last  = 1'b1;
            bus.out_data  = frame_byte(r_frame, r_seq, FINAL_IDX);
            if (bus.out_ready) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = TX_BYTE_A;
               end else begin
                  w_state_next = TX_IDLE;
               end
            end
         end
         default: w_state_next = TX_IDLE;
      endcase
   end
endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: LSB-first and MSB-first instances share clock and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_result_tx;
   import alu_result_tx_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy0, busy1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   alu_result_tx_if if0 ();
   alu_result_tx_if if1 ();

   alu_result_tx #(.DEPTH(2), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0)
   );
   alu_result_tx #(.DEPTH(2), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      if0.res_valid = 0; if0.res_q = '0; if0.carry_q = 0; if0.out_ready = 0;
      if1.res_valid = 0; if1.res_q = '0; if1.carry_q = 0; if1.out_ready = 0;
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid0: got %b want 0", if0.out_valid); end
      total++; if (if0.out_data !== 8'h00) begin bad++; $display("FAIL reset_data0: got %h want 00", if0.out_data); end
      total++; if (if0.out_last !== 1'b0) begin bad++; $display("FAIL reset_last0: got %b want 0", if0.out_last); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy0: got %b want 0", busy0); end
      total++; if (if0.res_ready !== 1'b1) begin bad++; $display("FAIL reset_ready0: got %b want 1", if0.res_ready); end
      total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid1: got %b want 0", if1.out_valid); end
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b want 0", busy1); end
      $display("[tb] reset checked");
   endtask

   task automatic test_single_frame();
      logic [7:0] exp_b [3] = '{8'hC3, 8'hA5, 8'h82};
      do_reset();
      @(negedge clk);
      if0.res_valid = 1; if0.res_q = 18'h2A5C3; if0.carry_q = 1; if0.out_ready = 1;
      @(negedge clk);
      if0.res_valid = 0;
      total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL single_latency: got valid %b want 0", if0.out_valid); end
      total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL single_busy_q: got %b want 1", busy0); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         $display("[tb] single byte%0d data=%h last=%b", i, if0.out_data, if0.out_last);
         total++; if (if0.out_valid !== 1'b1 || if0.out_data !== exp_b[i])
            begin bad++; $display("FAIL single_byte%0d: got v=%b %h want v=1 %h", i, if0.out_valid, if0.out_data, exp_b[i]); end
         total++; if (if0.out_last !== (i == 2))
            begin bad++; $display("FAIL single_last%0d: got %b want %b", i, if0.out_last, (i == 2)); end
      end
      @(negedge clk);
      total++; if (if0.out_valid !== 1'b0 || busy0 !== 1'b0 || if0.out_data !== 8'h00)
         begin bad++; $display("FAIL single_done: got v=%b busy=%b d=%h want 0 0 00", if0.out_valid, busy0, if0.out_data); end
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      if0.res_valid = 1; if0.res_q = 18'h2A5C3; if0.carry_q = 1; if0.out_ready = 1;
      @(negedge clk);
      if0.res_valid = 0;
      @(negedge clk);
      total++; if (if0.out_data !== 8'hC3) begin bad++; $display("FAIL bp_byte0: got %h want c3", if0.out_data); end
      @(negedge clk);
      if0.out_ready = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         $display("[tb] stall cycle %0d data=%h valid=%b", i, if0.out_data, if0.out_valid);
         total++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'hA5 || if0.out_last !== 1'b0)
            begin bad++; $display("FAIL bp_hold%0d: got v=%b %h l=%b want 1 a5 0", i, if0.out_valid, if0.out_data, if0.out_last); end
      end
      if0.out_ready = 1;
      @(negedge clk);
      total++; if (if0.out_data !== 8'h82 || if0.out_last !== 1'b1)
         begin bad++; $display("FAIL bp_byte2: got %h l=%b want 82 1", if0.out_data, if0.out_last); end
      @(negedge clk);
      total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL bp_end: got v=%b want 0", if0.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [17:0] w_res [4] = '{18'h00102, 18'h00304, 18'h10506, 18'h20708};
      logic        w_cy  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0]  exp_b [12] = '{8'h02, 8'h01, 8'h00, 8'h04, 8'h03, 8'h90,
                                  8'h06, 8'h05, 8'h21, 8'h08, 8'h07, 8'hB2};
      logic acc;
      do_reset();
      if0.out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if0.res_valid = 1; if0.res_q = w_res[k]; if0.carry_q = w_cy[k];
         total++; if (if0.res_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept%0d: got %b want 1", k, if0.res_ready); end
      end
      @(negedge clk);
      if0.res_q = w_res[3]; if0.carry_q = w_cy[3];
      for (int h = 0; h < 3; h++) begin
         if (h > 0) @(negedge clk);
         total++; if (if0.res_ready !== 1'b0) begin bad++; $display("FAIL b2b_full%0d: got %b want 0", h, if0.res_ready); end
         total++; if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h02)
            begin bad++; $display("FAIL b2b_head%0d: got v=%b %h want 1 02", h, if0.out_valid, if0.out_data); end
      end
      @(negedge clk);
      if0.out_ready = 1;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (acc) if0.res_valid = 0;
         end
         $display("[tb] b2b byte%0d data=%h last=%b", i, if0.out_data, if0.out_last);
         total++; if (if0.out_valid !== 1'b1 || if0.out_data !== exp_b[i] || if0.out_last !== (i % 3 == 2))
            begin bad++; $display("FAIL b2b_byte%0d: got v=%b %h l=%b want 1 %h %b", i, if0.out_valid, if0.out_data, if0.out_last, exp_b[i], (i % 3 == 2)); end
         acc = if0.res_valid && if0.res_ready;
      end
      @(negedge clk);
      total++; if (if0.out_valid !== 1'b0 || busy0 !== 1'b0)
         begin bad++; $display("FAIL b2b_end: got v=%b busy=%b want 0 0", if0.out_valid, busy0); end
   endtask

   task automatic test_seq_wrap();
      logic [7:0] exp_b2 [9] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h00};
      bit found;
      int cyc;
      do_reset();
      if0.out_ready = 1;
      for (int f = 0; f < 9; f++) begin
         @(negedge clk);
         if0.res_valid = 1; if0.res_q = '0; if0.carry_q = 0;
         @(negedge clk);
         if0.res_valid = 0;
         found = 0; cyc = 0;
         while (!found && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (if0.out_valid && if0.out_last) begin
               found = 1;
               $display("[tb] seq frame %0d byte2=%h", f, if0.out_data);
               total++; if (if0.out_data !== exp_b2[f])
                  begin bad++; $display("FAIL seq_frame%0d: got %h want %h", f, if0.out_data, exp_b2[f]); end
            end
         end
         if (!found) begin total++; bad++; $display("FAIL seq_timeout%0d: got no last want last", f); end
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] exp_b [3] = '{8'h82, 8'hA5, 8'hC3};
      do_reset();
      @(negedge clk);
      if1.res_valid = 1; if1.res_q = 18'h2A5C3; if1.carry_q = 1; if1.out_ready = 1;
      @(negedge clk);
      if1.res_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         $display("[tb] msb byte%0d data=%h last=%b", i, if1.out_data, if1.out_last);
         total++; if (if1.out_valid !== 1'b1 || if1.out_data !== exp_b[i] || if1.out_last !== (i == 2))
            begin bad++; $display("FAIL msb_byte%0d: got v=%b %h l=%b want 1 %h %b", i, if1.out_valid, if1.out_data, if1.out_last, exp_b[i], (i == 2)); end
      end
      @(negedge clk);
      total++; if (if1.out_valid !== 1'b0 || busy1 !== 1'b0)
         begin bad++; $display("FAIL msb_end: got v=%b busy=%b want 0 0", if1.out_valid, busy1); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] got [3];
      logic       lst [3];
      int n, cyc;
      do_reset();
      if0.out_ready = 1;
      // one complete frame first so seq is non-zero before the reset
      @(negedge clk);
      if0.res_valid = 1; if0.res_q = '0; if0.carry_q = 0;
      @(negedge clk);
      if0.res_valid = 0;
      repeat (4) @(negedge clk);
      if0.res_valid = 1; if0.res_q = 18'h2A5C3; if0.carry_q = 1;
      @(negedge clk);
      if0.res_q = 18'h11111; if0.carry_q = 0;
      @(negedge clk);
      if0.res_valid = 0;
      @(negedge clk);
      total++; if (if0.out_data !== 8'hA5 || busy0 !== 1'b1)
         begin bad++; $display("FAIL mid_pending: got %h busy=%b want a5 1", if0.out_data, busy0); end
      if0.out_ready = 0;
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      total++; if (if0.out_valid !== 1'b0 || if0.res_ready !== 1'b1 || busy0 !== 1'b0)
         begin bad++; $display("FAIL mid_after_reset: got v=%b rdy=%b busy=%b want 0 1 0", if0.out_valid, if0.res_ready, busy0); end
      @(negedge clk);
      if0.out_ready = 1;
      if0.res_valid = 1; if0.res_q = '0; if0.carry_q = 0;
      @(negedge clk);
      if0.res_valid = 0;
      n = 0; cyc = 0;
      while (n < 3 && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (if0.out_valid) begin got[n] = if0.out_data; lst[n] = if0.out_last; n++; end
      end
      total++; if (n !== 3) begin bad++; $display("FAIL mid_count: got %0d want 3", n); end
      for (int i = 0; i < n; i++) begin
         $display("[tb] post-reset byte%0d data=%h last=%b", i, got[i], lst[i]);
         total++; if (got[i] !== 8'h00 || lst[i] !== (i == 2))
            begin bad++; $display("FAIL mid_byte%0d: got %h l=%b want 00 %b", i, got[i], lst[i], (i == 2)); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_back_to_back();
      test_seq_wrap();
      test_msb_first();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
